// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory port, redirect request and
// the valid/ready decode channel. "master" is the fetch unit's view and
// "slave" is the view of the surrounding memory/decode environment.
interface instr_fetch_unit_if;
    logic [31:0] imem_a;
    logic [31:0] imem_rd;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        fetch_fault;

    modport master (
        output imem_a, id_valid, id_instr, id_pc, fetch_fault,
        input  imem_rd, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_a, id_valid, id_instr, id_pc, fetch_fault,
        output imem_rd, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, addresses InstructionMemory, and
// buffers {pc, instr} pairs in a small FIFO towards decode.
// Redirects flush the buffer. A misaligned or out-of-range redirect target
// parks the unit in FAULT until a legal redirect or a reset arrives.
// Optional feature macro: FETCH_PERF_CNT_EN adds saturating fetch/stall
// counters on perf_fetch_cnt / perf_stall_cnt.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC         = 32'h0000_0000,
    parameter int          IMEM_DEPTH_WORDS = 256,
    parameter int          FIFO_DEPTH       = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    instr_fetch_unit_if.master        bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]               perf_fetch_cnt,
    output logic [31:0]               perf_stall_cnt
`endif
);

    localparam int          PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          CW       = PW + 1;
    localparam logic [31:0] PC_LIMIT = 32'(4 * IMEM_DEPTH_WORDS);
    localparam logic [31:0] LAST_PC  = 32'(4 * IMEM_DEPTH_WORDS - 4);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]   count_q;
    logic [31:0]     fifo_pc    [FIFO_DEPTH];
    logic [31:0]     fifo_instr [FIFO_DEPTH];
    logic [31:0]     hold_pc_q, hold_instr_q;
    logic            push, pop, flush;
    logic            fifo_empty, fifo_full, target_ok;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign target_ok  = (bus.redirect_pc[1:0] == 2'b00) && (bus.redirect_pc < PC_LIMIT);

    // Outputs: memory is addressed straight from the PC register; the head
    // entry is shown while the buffer holds data, otherwise the last head.
    assign bus.imem_a      = pc_q;
    assign bus.id_valid    = !fifo_empty;
    assign bus.id_pc       = fifo_empty ? hold_pc_q    : fifo_pc[rd_ptr_q];
    assign bus.id_instr    = fifo_empty ? hold_instr_q : fifo_instr[rd_ptr_q];
    assign bus.fetch_fault = (state_q == ST_FAULT);

    // Next-state logic: redirect outranks push/pop; RUN fetches whenever
    // the buffer has room (or makes room through a same-cycle pop).
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        if (bus.redirect_valid) begin
            flush = 1'b1;
            if (target_ok) begin
                state_d = ST_RUN;
                pc_d    = bus.redirect_pc;
            end else begin
                state_d = ST_FAULT;
            end
        end else begin
            pop = !fifo_empty && bus.id_ready;
            case (state_q)
                ST_RUN: begin
                    push = !fifo_full || pop;
                    if (push) begin
                        pc_d = (pc_q == LAST_PC) ? 32'h0 : pc_q + 32'd4;
                    end
                end
                default: begin
                    push = 1'b0;
                end
            endcase
        end
    end

    // Control state: FSM, PC, FIFO pointers/occupancy and held head value.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            hold_pc_q    <= 32'h0;
            hold_instr_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_pc_q    <= bus.id_pc;
            hold_instr_q <= bus.id_instr;
            if (flush) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end

    // FIFO storage: written only on push, never reset (occupancy gates use).
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr_q]    <= pc_q;
            fifo_instr[wr_ptr_q] <= bus.imem_rd;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating performance counters; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_cnt <= 32'h0;
            perf_stall_cnt <= 32'h0;
        end else begin
            if (push && (perf_fetch_cnt != 32'hFFFF_FFFF))
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (bus.id_valid && !bus.id_ready && (perf_stall_cnt != 32'hFFFF_FFFF))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by
// randomized ready/redirect/reset traffic, checked against a queue model.
module tb_instr_fetch_unit;

    localparam int DEPTH_W = 256;
    localparam int FDEPTH  = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic clk;
    logic reset;
    instr_fetch_unit_if ifc ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    instr_fetch_unit #(
        .RESET_PC         (32'h0),
        .IMEM_DEPTH_WORDS (DEPTH_W),
        .FIFO_DEPTH       (FDEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (ifc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    // Instruction memory with random contents, read combinationally.
    logic [31:0] imem [DEPTH_W];
    assign ifc.imem_rd = imem[ifc.imem_a[9:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the decode side sees the address sequence starting at
    // the last reset/legal redirect target, +4 mod memory size, each address once.
    ent_t        q[$];
    logic [31:0] m_pc     = 32'h0;
    logic        m_fault  = 1'b0;
    ent_t        m_last   = '{pc: 32'h0, instr: 32'h0};
    int unsigned m_fetch  = 0;
    int unsigned m_stall  = 0;

    always @(posedge clk) begin
        int tgt;
        bit popped;
        if (q.size() > 0) m_last = q[0];
        if (reset) begin
            q.delete();
            m_pc    = 32'h0;
            m_fault = 1'b0;
            m_last  = '{pc: 32'h0, instr: 32'h0};
            m_fetch = 0;
            m_stall = 0;
        end else begin
            if (q.size() > 0 && !ifc.id_ready) m_stall++;
            if (ifc.redirect_valid) begin
                q.delete();
                tgt = int'(ifc.redirect_pc);
                if (ifc.redirect_pc % 4 == 0 && ifc.redirect_pc < 4 * DEPTH_W) begin
                    m_pc    = ifc.redirect_pc;
                    m_fault = 1'b0;
                end else begin
                    m_fault = 1'b1;
                end
            end else begin
                popped = (q.size() > 0) && ifc.id_ready;
                if (popped) void'(q.pop_front());
                if (!m_fault && q.size() < FDEPTH) begin
                    q.push_back('{pc: m_pc, instr: imem[m_pc / 4]});
                    m_pc = (m_pc + 4) % (4 * DEPTH_W);
                    m_fetch++;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: compare the presented outputs against the model every cycle.
    always @(negedge clk) begin
        check("id_valid", 32'(ifc.id_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            check("id_pc", ifc.id_pc, q[0].pc);
            check("id_instr", ifc.id_instr, q[0].instr);
        end else begin
            check("id_pc_hold", ifc.id_pc, m_last.pc);
            check("id_instr_hold", ifc.id_instr, m_last.instr);
        end
        check("imem_a", ifc.imem_a, m_pc);
        check("fetch_fault", 32'(ifc.fetch_fault), 32'(m_fault));
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetch_cnt", perf_fetch_cnt, 32'(m_fetch));
        check("perf_stall_cnt", perf_stall_cnt, 32'(m_stall));
`endif
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic redirect(input logic [31:0] tgt);
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = tgt;
        tick(1);
        ifc.redirect_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH_W; i++) imem[i] = $urandom;
        imem[0] = 32'hA0; imem[1] = 32'hA1; imem[2] = 32'hA2; imem[3] = 32'hA3;
        reset              = 1'b1;
        ifc.redirect_valid = 1'b0;
        ifc.redirect_pc    = 32'h0;
        ifc.id_ready       = 1'b1;
        tick(2);
        reset = 1'b0;
        // Streaming from reset
        tick(6);
        // Backpressure then drain
        ifc.id_ready = 1'b0;
        tick(5);
        ifc.id_ready = 1'b1;
        tick(6);
        // Redirect to last word, wrap to 0
        redirect(32'h3FC);
        tick(4);
        // Illegal redirect, then recovery
        redirect(32'h3FF);
        tick(3);
        redirect(32'h400);
        tick(2);
        redirect(32'h10);
        tick(4);
        // Redirect while full and popping
        ifc.id_ready = 1'b0;
        tick(4);
        ifc.id_ready = 1'b1;
        redirect(32'h40);
        tick(4);
        // Mid-stream reset
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(3);
        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            int r;
            ifc.id_ready = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 99);
            if (r < 1) begin
                reset = 1'b1;
                tick(1);
                reset = 1'b0;
            end else if (r < 6) begin
                case ($urandom_range(0, 3))
                    0: redirect({22'h0, 8'($urandom_range(0, DEPTH_W - 1)), 2'b00});
                    1: redirect(32'h3FC);
                    2: redirect({22'h0, 8'($urandom), 2'($urandom_range(1, 3))});
                    default: redirect(32'h400 + 32'($urandom_range(0, 4096)) * 4);
                endcase
            end else begin
                tick(1);
            end
        end
        ifc.id_ready = 1'b1;
        tick(4);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
